spi_signal_bit_dc_master: RTL and testbench

SPI master counterpart of the Hamming-protected single-word SPI slave. On each `start` it Hamming(12,8)-encodes one byte and runs one full-duplex 12-bit SPI frame in mode 0. It drives `cs`, `sck` and `mo`, and captures the slave's 12-bit codeword on `mi`. It then decodes that codeword, corrects single-bit errors, and reports the result with a one-cycle `done` pulse.

---
 rtl/spi_signal_bit_dc_master.sv | 237 +++++++++++++++++++++++
 tb/tb_spi_signal_bit_dc_master.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/spi_signal_bit_dc_master.sv
// spi_signal_bit_dc_master: SPI mode-0 master for one Hamming(12,8) protected word.
// Each accepted start encodes din and shifts the 12-bit codeword MSB first on mo.
// It captures the slave's 12-bit codeword on mi, decodes it, corrects single errors,
// and pulses done when the results are valid.
// Ports:
//   clk, rst (async active-low), start, din[7:0]       - control / payload in
//   cs, sck, mo, mi                                    - SPI pins (mi already synchronous)
//   busy                                               - accept through done, inclusive
//   tx_word[11:0]                                      - codeword being sent
//   dout[7:0], err_addr[3:0], error_only, error_mul    - decode results
//   done                                               - one-cycle valid pulse
module spi_signal_bit_dc_master #(
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned CS_SETUP = 2,
    parameter int unsigned CS_HOLD  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  din,
    output logic        busy,
    output logic        cs,
    output logic        sck,
    output logic        mo,
    input  logic        mi,
    output logic [11:0] tx_word,
    output logic [7:0]  dout,
    output logic [3:0]  err_addr,
    output logic        error_only,
    output logic        error_mul,
    output logic        done
);

    // The counter serves the setup, half-period and hold phases.
    // Hold counts one extra step for the cs-high cycle ahead of DECODE.
    localparam int unsigned HOLD_MAX = CS_HOLD + 1;
    localparam int unsigned MAX_A    = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
    localparam int unsigned CNT_MAX  = (MAX_A > HOLD_MAX) ? MAX_A : HOLD_MAX;
    localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);
    localparam int unsigned CW_W     = 12;
    localparam int unsigned BIT_W    = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_DECODE
    } state_t;

    // Even-parity Hamming(12,8): cw[i-1] holds position i; parity at 1, 2, 4 and 8.
    function automatic logic [CW_W-1:0] hamming_encode(input logic [7:0] d);
        logic [CW_W-1:0] cw;
        cw      = '0;
        cw[2]   = d[0];
        cw[4]   = d[1];
        cw[5]   = d[2];
        cw[6]   = d[3];
        cw[8]   = d[4];
        cw[9]   = d[5];
        cw[10]  = d[6];
        cw[11]  = d[7];
        cw[0]   = cw[2] ^ cw[4] ^ cw[6] ^ cw[8] ^ cw[10];
        cw[1]   = cw[2] ^ cw[5] ^ cw[6] ^ cw[9] ^ cw[10];
        cw[3]   = cw[4] ^ cw[5] ^ cw[6] ^ cw[11];
        cw[7]   = cw[8] ^ cw[9] ^ cw[10] ^ cw[11];
        return cw;
    endfunction

    // Syndrome {s8,s4,s2,s1} over the received word, each parity bit included.
    function automatic logic [3:0] hamming_syndrome(input logic [CW_W-1:0] r);
        logic [3:0] s;
        s[0] = r[0] ^ r[2] ^ r[4] ^ r[6] ^ r[8] ^ r[10];
        s[1] = r[1] ^ r[2] ^ r[5] ^ r[6] ^ r[9] ^ r[10];
        s[2] = r[3] ^ r[4] ^ r[5] ^ r[6] ^ r[11];
        s[3] = r[7] ^ r[8] ^ r[9] ^ r[10] ^ r[11];
        return s;
    endfunction

    state_t            state, state_d;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic [BIT_W-1:0]  bit_idx, bit_idx_d;
    logic              phase, phase_d;
    logic [CW_W-1:0]   rx_word, rx_word_d;
    logic [CW_W-1:0]   tx_word_d;
    logic              cs_d, sck_d, mo_d, busy_d, done_d;
    logic [7:0]        dout_d;
    logic [3:0]        err_addr_d;
    logic              error_only_d, error_mul_d;

    logic [3:0]        dec_syn_c;
    logic [CW_W-1:0]   dec_fix_c;
    logic [7:0]        dec_data_c;
    logic              dec_single_c, dec_multi_c;

    // Decode of the captured word; flips the flagged position only for syndromes 1..12.
    always_comb begin
        dec_syn_c    = hamming_syndrome(rx_word);
        dec_single_c = (dec_syn_c != 4'd0) && (dec_syn_c <= 4'd12);
        dec_multi_c  = (dec_syn_c >= 4'd13);
        dec_fix_c    = rx_word;
        for (int i = 0; i < 12; i++) begin
            if (dec_syn_c == 4'(i + 1)) begin
                dec_fix_c[i] = ~rx_word[i];
            end
        end
        dec_data_c = {dec_fix_c[11], dec_fix_c[10], dec_fix_c[9], dec_fix_c[8],
                      dec_fix_c[6],  dec_fix_c[5],  dec_fix_c[4], dec_fix_c[2]};
    end

    // Next-state and next-output logic; pin values are registered one cycle after the
    // state that produces them, so sck/cs/mo come straight from flops.
    always_comb begin
        state_d      = state;
        cnt_d        = cnt;
        bit_idx_d    = bit_idx;
        phase_d      = phase;
        rx_word_d    = rx_word;
        tx_word_d    = tx_word;
        cs_d         = 1'b1;
        sck_d        = 1'b0;
        mo_d         = 1'b0;
        busy_d       = busy;
        done_d       = 1'b0;
        dout_d       = dout;
        err_addr_d   = err_addr;
        error_only_d = error_only;
        error_mul_d  = error_mul;

        case (state)
            S_IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    state_d   = S_SETUP;
                    cnt_d     = '0;
                    tx_word_d = hamming_encode(din);
                    busy_d    = 1'b1;
                end
            end
            S_SETUP: begin
                cs_d = 1'b0;
                mo_d = tx_word[11];
                if (cnt == CNT_W'(CS_SETUP - 1)) begin
                    state_d   = S_SHIFT;
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    phase_d   = 1'b0;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            S_SHIFT: begin
                cs_d  = 1'b0;
                sck_d = phase;
                mo_d  = tx_word[BIT_W'(11) - bit_idx];
                // Sample mi on the edge that raises sck.
                if (phase && (cnt == '0)) begin
                    rx_word_d = {rx_word[CW_W-2:0], mi};
                end
                if (cnt == CNT_W'(CLK_DIV - 1)) begin
                    cnt_d = '0;
                    if (!phase) begin
                        phase_d = 1'b1;
                    end else begin
                        phase_d = 1'b0;
                        if (bit_idx == BIT_W'(11)) begin
                            state_d = S_HOLD;
                        end else begin
                            bit_idx_d = bit_idx + BIT_W'(1);
                        end
                    end
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            S_HOLD: begin
                cs_d = 1'b0;
                if (cnt == CNT_W'(CS_HOLD)) begin
                    cs_d    = 1'b1;
                    state_d = S_DECODE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            S_DECODE: begin
                done_d       = 1'b1;
                dout_d       = dec_data_c;
                err_addr_d   = dec_syn_c;
                error_only_d = dec_single_c;
                error_mul_d  = dec_multi_c;
                state_d      = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            phase      <= 1'b0;
            rx_word    <= '0;
            tx_word    <= '0;
            cs         <= 1'b1;
            sck        <= 1'b0;
            mo         <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            dout       <= '0;
            err_addr   <= '0;
            error_only <= 1'b0;
            error_mul  <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            bit_idx    <= bit_idx_d;
            phase      <= phase_d;
            rx_word    <= rx_word_d;
            tx_word    <= tx_word_d;
            cs         <= cs_d;
            sck        <= sck_d;
            mo         <= mo_d;
            busy       <= busy_d;
            done       <= done_d;
            dout       <= dout_d;
            err_addr   <= err_addr_d;
            error_only <= error_only_d;
            error_mul  <= error_mul_d;
        end
    end

endmodule

// File: tb/tb_spi_signal_bit_dc_master.sv
// Directed bench for spi_signal_bit_dc_master with default parameters.
// The slave is modelled as a loopback (mi = mo) with optional per-bit inversion.
// Edge numbering: e = k means the sample taken at the negedge after clock edge k,
// where edge 0 is the edge that samples start.
module tb_spi_signal_bit_dc_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  din;
    logic        busy, cs, sck, mo, mi;
    logic [11:0] tx_word;
    logic [7:0]  dout;
    logic [3:0]  err_addr;
    logic        error_only, error_mul, done;

    int n_assert = 0;
    int n_fail   = 0;

    logic [11:0] mo_seq;
    int          rises, cs_low, first_rise, cs_rise, done_at, done_cnt, busy_fall;
    logic        busy0;

    spi_signal_bit_dc_master #(.CLK_DIV(4), .CS_SETUP(2), .CS_HOLD(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .din        (din),
        .busy       (busy),
        .cs         (cs),
        .sck        (sck),
        .mo         (mo),
        .mi         (mi),
        .tx_word    (tx_word),
        .dout       (dout),
        .err_addr   (err_addr),
        .error_only (error_only),
        .error_mul  (error_mul),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One frame: fl[k-1] inverts mi during bit k; pulse_at injects a start with a
    // different din mid-frame; rst_at pulses reset at that sample point.
    task automatic run_frame(input logic [7:0] d, input logic [11:0] fl,
                             input int pulse_at, input int rst_at);
        logic prev_sck, prev_cs, prev_busy;
        @(negedge clk);
        din   = d;
        start = 1'b1;
        mi    = 1'b0;
        mo_seq = '0;
        rises = 0; cs_low = 0; first_rise = -1; cs_rise = -1;
        done_at = -1; done_cnt = 0; busy_fall = -1; busy0 = 1'b0;
        prev_sck = 1'b0; prev_cs = 1'b1; prev_busy = 1'b1;
        for (int e = 0; e < 200; e++) begin
            @(negedge clk);
            if (e == 0) begin
                start = 1'b0;
                busy0 = busy;
            end
            if (pulse_at >= 0 && e == pulse_at) begin
                din   = 8'h3C;
                start = 1'b1;
            end
            if (pulse_at >= 0 && e == pulse_at + 1) start = 1'b0;
            if (rst_at >= 0 && e == rst_at) begin
                rst = 1'b0;
                #1;
                check("rst_mid_cs", 32'(cs), 32'd1);
                check("rst_mid_sck", 32'(sck), 32'd0);
                check("rst_mid_mo", 32'(mo), 32'd0);
                #2 rst = 1'b1;
            end
            if (!cs) cs_low++;
            if (sck && !prev_sck) begin
                if (rises < 12) mo_seq[11 - rises] = mo;
                if (first_rise < 0) first_rise = e;
                rises++;
            end
            if (cs && !prev_cs && cs_rise < 0) cs_rise = e;
            if (done) begin
                done_cnt++;
                if (done_at < 0) done_at = e;
            end
            if (!busy && prev_busy && busy_fall < 0) busy_fall = e;
            mi = mo ^ ((rises < 12) ? fl[rises] : 1'b0);
            prev_sck = sck; prev_cs = cs; prev_busy = busy;
            if (done_at >= 0 && e > done_at + 2) break;
        end
    endtask

    initial begin
        int gap, dones, falls;
        logic pcs;
        rst = 1'b0; start = 1'b0; din = 8'h00; mi = 1'b0;
        #12;
        check("reset_cs", 32'(cs), 32'd1);
        check("reset_sck", 32'(sck), 32'd0);
        check("reset_mo", 32'(mo), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_tx_word", 32'(tx_word), 32'd0);
        check("reset_dout", 32'(dout), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Clean loopback of 0xA5: encode, wire order and frame timing.
        run_frame(8'hA5, 12'h000, -1, -1);
        check("a5_busy_at_accept", 32'(busy0), 32'd1);
        check("a5_tx_word", 32'(tx_word), 32'hA27);
        check("a5_mo_sequence", 32'(mo_seq), 32'hA27);
        check("a5_sck_rises", 32'(rises), 32'd12);
        check("a5_cs_low_cycles", 32'(cs_low), 32'd100);
        check("a5_first_rise_edge", 32'(first_rise), 32'd7);
        check("a5_cs_rise_edge", 32'(cs_rise), 32'd101);
        check("a5_done_edge", 32'(done_at), 32'd102);
        check("a5_done_width", 32'(done_cnt), 32'd1);
        check("a5_busy_fall_edge", 32'(busy_fall), 32'd103);
        check("a5_dout", 32'(dout), 32'hA5);
        check("a5_err_addr", 32'(err_addr), 32'd0);
        check("a5_error_only", 32'(error_only), 32'd0);
        check("a5_error_mul", 32'(error_mul), 32'd0);

        // Single error in bit 7 (position 6) is corrected.
        run_frame(8'hA5, 12'h040, -1, -1);
        check("single_dout", 32'(dout), 32'hA5);
        check("single_err_addr", 32'(err_addr), 32'd6);
        check("single_error_only", 32'(error_only), 32'd1);
        check("single_error_mul", 32'(error_mul), 32'd0);
        check("single_done_edge", 32'(done_at), 32'd102);

        // Errors in bits 1 and 12 (positions 12 and 1) alias to syndrome 13.
        run_frame(8'hA5, 12'h801, -1, -1);
        check("double_err_addr", 32'(err_addr), 32'd13);
        check("double_error_mul", 32'(error_mul), 32'd1);
        check("double_error_only", 32'(error_only), 32'd0);
        check("double_dout", 32'(dout), 32'h25);

        // start with a new din during SHIFT is ignored.
        run_frame(8'h5A, 12'h000, 30, -1);
        check("ignore_tx_word", 32'(tx_word), 32'h550);
        check("ignore_dout", 32'(dout), 32'h5A);
        check("ignore_done_count", 32'(done_cnt), 32'd1);
        check("ignore_done_edge", 32'(done_at), 32'd102);

        // Reset during bit 5 abandons the frame with no done.
        run_frame(8'h96, 12'h000, -1, 40);
        check("rst_no_done", 32'(done_cnt), 32'd0);
        check("rst_idle_cs", 32'(cs), 32'd1);
        check("rst_idle_busy", 32'(busy), 32'd0);
        run_frame(8'h96, 12'h000, -1, -1);
        check("after_rst_tx_word", 32'(tx_word), 32'h93A);
        check("after_rst_dout", 32'(dout), 32'h96);
        check("after_rst_err_addr", 32'(err_addr), 32'd0);
        check("after_rst_done_edge", 32'(done_at), 32'd102);
        check("after_rst_rises", 32'(rises), 32'd12);

        // start held high gives back-to-back frames separated by a short cs-high gap.
        @(negedge clk);
        din = 8'hC3; start = 1'b1;
        gap = 0; dones = 0; falls = 0; pcs = cs;
        for (int e = 0; e < 400 && dones < 2; e++) begin
            @(negedge clk);
            mi = mo;
            if (done) dones++;
            if (!cs && pcs) falls++;
            if (cs && falls == 1) gap++;
            pcs = cs;
        end
        start = 1'b0;
        check("b2b_two_frames", 32'(dones), 32'd2);
        check("b2b_gap_in_range", 32'((gap >= 1) && (gap <= 3)), 32'd1);
        check("b2b_dout", 32'(dout), 32'hC3);
        repeat (4) @(negedge clk);
        check("b2b_idle_busy", 32'(busy), 32'd0);
        check("b2b_idle_cs", 32'(cs), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
